// File: rtl/sd_dat_crc16_lanes_pkg.sv
// Shared types and constants for the SD DAT CRC16 lane unit.
// The END state is only reachable when SD_CRC_END_BIT_EN is defined.
package sd_crc_pkg;

    localparam int          CRC_BITS   = 16;
    localparam logic [15:0] CRC16_POLY = 16'h1021;
    localparam logic        MODE_GEN   = 1'b0;
    localparam logic        MODE_CHK   = 1'b1;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_CRC,
        ST_END,
        ST_DONE
    } state_e;

    // One serial CRC16-CCITT step, data bit entering at the MSB side.
    function automatic logic [15:0] crc16_step(
        input logic [15:0] c,
        input logic        b
    );
        logic inv;
        inv = b ^ c[15];
        return {c[14:0], 1'b0} ^ (inv ? CRC16_POLY : 16'h0000);
    endfunction

endpackage

// File: rtl/sd_dat_crc16_lanes_lane.sv
// One DAT lane: serial CRC16 LFSR with load, data feed and
// zero-fill shift-out controls.
module sd_crc16_lane
    import sd_crc_pkg::*;
#(
    parameter logic [15:0] INIT = 16'h0000
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        load_i,
    input  logic        feed_i,
    input  logic        shift_i,
    input  logic        bit_i,
    output logic [15:0] crc_o
);

    logic [15:0] crc_q;
    logic [15:0] crc_d;

    always_comb begin
        crc_d = crc_q;
        if (feed_i) begin
            crc_d = crc16_step(crc_q, bit_i);
        end else if (shift_i) begin
            crc_d = {crc_q[14:0], 1'b0};
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || load_i) begin
            crc_q <= INIT;
        end else begin
            crc_q <= crc_d;
        end
    end

    assign crc_o = crc_q;

endmodule

// File: rtl/sd_dat_crc16_lanes.sv
// Multi-lane SD DAT CRC16 generator/checker, one LFSR per lane.
// Define SD_CRC_END_BIT_EN to add the end-bit slot after the CRC.
module sd_dat_crc16_lanes
    import sd_crc_pkg::*;
#(
    parameter int          LANES      = 4,
    parameter int          BLOCK_BITS = 1024,
    parameter logic [15:0] INIT       = 16'h0000
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  ENA,
    input  logic                  START,
    input  logic                  MODE,
    input  logic [LANES-1:0]      BITVAL,
    output logic [LANES-1:0]      CRC_OUT,
    output logic                  CRC_PHASE,
    output logic                  BUSY,
    output logic                  DONE,
    output logic [LANES-1:0]      CRC_ERR,
    output logic [16*LANES-1:0]   CRC
);

    localparam logic [15:0] LAST_BIT  = 16'(BLOCK_BITS - 1);
    localparam logic [3:0]  LAST_SLOT = 4'(CRC_BITS - 1);

    state_e           state_q;
    state_e           state_d;
    logic [15:0]      cnt_q;
    logic [15:0]      cnt_d;
    logic [3:0]       slot_q;
    logic [3:0]       slot_d;
    logic             mode_q;
    logic             mode_d;
    logic [LANES-1:0] err_q;
    logic [LANES-1:0] err_d;

    logic             load;
    logic             feed;
    logic             shift;
    logic [LANES-1:0] msb;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        slot_d  = slot_q;
        mode_d  = mode_q;
        err_d   = err_q;
        load    = 1'b0;
        feed    = 1'b0;
        shift   = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (START) begin
                    state_d = ST_DATA;
                    load    = 1'b1;
                    mode_d  = MODE;
                    err_d   = '0;
                    cnt_d   = '0;
                end
            end
            ST_DATA: begin
                if (ENA) begin
                    feed  = 1'b1;
                    cnt_d = cnt_q + 16'd1;
                    if (cnt_q == LAST_BIT) begin
                        state_d = ST_CRC;
                        slot_d  = '0;
                    end
                end
            end
            ST_CRC: begin
                if (ENA) begin
                    shift  = 1'b1;
                    slot_d = slot_q + 4'd1;
                    if (mode_q == MODE_CHK) begin
                        err_d = err_q | (BITVAL ^ msb);
                    end
                    if (slot_q == LAST_SLOT) begin
`ifdef SD_CRC_END_BIT_EN
                        state_d = ST_END;
`else
                        state_d = ST_DONE;
`endif
                    end
                end
            end
`ifdef SD_CRC_END_BIT_EN
            ST_END: begin
                if (ENA) begin
                    if (mode_q == MODE_CHK) begin
                        err_d = err_q | ~BITVAL;
                    end
                    state_d = ST_DONE;
                end
            end
`endif
            ST_DONE: begin
                state_d = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            slot_q  <= '0;
            mode_q  <= MODE_GEN;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            slot_q  <= slot_d;
            mode_q  <= mode_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        CRC_OUT   = '0;
        CRC_PHASE = (state_q == ST_CRC);
        BUSY      = (state_q == ST_DATA) || (state_q == ST_CRC)
                 || (state_q == ST_END);
        DONE      = (state_q == ST_DONE);
        if (state_q == ST_CRC && mode_q == MODE_GEN) begin
            CRC_OUT = msb;
        end
`ifdef SD_CRC_END_BIT_EN
        if (state_q == ST_END && mode_q == MODE_GEN) begin
            CRC_OUT = '1;
        end
`endif
    end

    assign CRC_ERR = err_q;

    for (genvar n = 0; n < LANES; n++) begin : g_lane
        sd_crc16_lane #(
            .INIT    (INIT)
        ) u_lane (
            .clk_i   (CLK),
            .rst_i   (RST),
            .load_i  (load),
            .feed_i  (feed),
            .shift_i (shift),
            .bit_i   (BITVAL[n]),
            .crc_o   (CRC[16*n +: 16])
        );
        assign msb[n] = CRC[16*n+15];
    end

endmodule

// File: tb/tb_sd_dat_crc16_lanes.sv
// Bench: 1-lane unit against a per-cycle reference model with random
// ENA gaps, plus a 4-lane unit with hand-computed expectations.
module tb_sd_dat_crc16_lanes;

    localparam int BBA = 72;
    localparam int BBB = 4096;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_a = 1'b1, ena_a = 1'b0, start_a = 1'b0, mode_a = 1'b0;
    logic [0:0]  bit_a = '0;
    logic [0:0]  out_a, err_a;
    logic        ph_a, busy_a, done_a;
    logic [15:0] crc_a;

    logic        rst_b = 1'b1, ena_b = 1'b0, start_b = 1'b0, mode_b = 1'b0;
    logic [3:0]  bit_b = '0;
    logic [3:0]  out_b, err_b;
    logic        ph_b, busy_b, done_b;
    logic [63:0] crc_b;

    sd_dat_crc16_lanes #(.LANES(1), .BLOCK_BITS(BBA), .INIT(16'h0000)) u_a (
        .CLK(clk), .RST(rst_a), .ENA(ena_a), .START(start_a),
        .MODE(mode_a), .BITVAL(bit_a), .CRC_OUT(out_a),
        .CRC_PHASE(ph_a), .BUSY(busy_a), .DONE(done_a),
        .CRC_ERR(err_a), .CRC(crc_a)
    );

    sd_dat_crc16_lanes #(.LANES(4), .BLOCK_BITS(BBB), .INIT(16'h0000)) u_b (
        .CLK(clk), .RST(rst_b), .ENA(ena_b), .START(start_b),
        .MODE(mode_b), .BITVAL(bit_b), .CRC_OUT(out_b),
        .CRC_PHASE(ph_b), .BUSY(busy_b), .DONE(done_b),
        .CRC_ERR(err_b), .CRC(crc_b)
    );

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // CRC as the remainder of M(x)*x^16 divided by the generator.
    function automatic logic [15:0] crc16(input bit msg[$]);
        logic [15:0] r;
        bit top;
        bit nb;
        r = 16'h0000;
        for (int i = 0; i < msg.size() + 16; i++) begin
            top = r[15];
            nb  = (i < msg.size()) ? msg[i] : 1'b0;
            r   = {r[14:0], nb};
            if (top) r = r ^ 16'h1021;
        end
        return r;
    endfunction

    // Reference model of unit A: 0 idle, 1 data, 2 crc, 3 end bit, 4 done.
    int          m_ph = 0;
    bit          m_q[$];
    int          m_slot = 0;
    bit          m_mode = 1'b0;
    bit          m_err = 1'b0;
    logic [15:0] m_crcv = 16'h0;

    initial begin
        logic        e_out;
        logic [15:0] e_crc;
        forever begin
            @(negedge clk);
            e_out = 1'b0;
            if (m_ph == 2 && !m_mode) e_out = m_crcv[15-m_slot];
            if (m_ph == 3 && !m_mode) e_out = 1'b1;
            e_crc = (m_ph == 1) ? crc16(m_q)
                  : (m_ph == 2) ? (m_crcv << m_slot) : 16'h0000;
            chk("a_cycle",
                {out_a, ph_a, busy_a, done_a, err_a, crc_a},
                {e_out, m_ph == 2, m_ph >= 1 && m_ph <= 3,
                 m_ph == 4, m_err, e_crc});
            if (rst_a) begin
                m_ph = 0;
                m_err = 1'b0;
                m_q.delete();
            end else begin
                case (m_ph)
                    0: if (start_a) begin
                        m_ph = 1;
                        m_q.delete();
                        m_mode = mode_a;
                        m_err = 1'b0;
                    end
                    1: if (ena_a) begin
                        m_q.push_back(bit_a[0]);
                        if (m_q.size() == BBA) begin
                            m_crcv = crc16(m_q);
                            m_slot = 0;
                            m_ph = 2;
                        end
                    end
                    2: if (ena_a) begin
                        if (m_mode) m_err |= bit_a[0] ^ m_crcv[15-m_slot];
                        m_slot++;
`ifdef SD_CRC_END_BIT_EN
                        if (m_slot == 16) m_ph = 3;
`else
                        if (m_slot == 16) m_ph = 4;
`endif
                    end
                    3: if (ena_a) begin
                        if (m_mode) m_err |= ~bit_a[0];
                        m_ph = 4;
                    end
                    default: m_ph = 0;
                endcase
            end
        end
    end

    task automatic a_slot(input bit b, input int gmax, output bit o);
        repeat ($urandom_range(gmax, 0)) begin
            @(posedge clk); #1;
        end
        ena_a = 1'b1;
        bit_a = b;
        @(negedge clk);
        o = out_a[0];
        @(posedge clk); #1;
        ena_a = 1'b0;
        bit_a = 1'($urandom);
    endtask

    task automatic a_block(input bit m, input bit d[BBA],
                           input logic [15:0] cb, input bit eb,
                           input int gmax, input int rs,
                           output logic [15:0] cap, output bit dn);
        bit o;
        start_a = 1'b1;
        mode_a  = m;
        ena_a   = 1'($urandom);
        @(posedge clk); #1;
        start_a = 1'b0;
        ena_a   = 1'b0;
        mode_a  = 1'($urandom);
        for (int i = 0; i < BBA; i++) a_slot(d[i], gmax, o);
        for (int k = 0; k < 16; k++) begin
            if (k == rs) begin
                start_a = 1'b1;
                mode_a  = ~m;
                @(posedge clk); #1;
                start_a = 1'b0;
            end
            a_slot(cb[15-k], gmax, o);
            cap[15-k] = o;
        end
`ifdef SD_CRC_END_BIT_EN
        a_slot(eb, gmax, o);
`else
        o = eb;
`endif
        @(negedge clk);
        dn = done_a;
        @(posedge clk); #1;
    endtask

    task automatic b_slot(input logic [3:0] v, output logic [3:0] o);
        ena_b = 1'b1;
        bit_b = v;
        @(negedge clk);
        o = out_b;
        @(posedge clk); #1;
        ena_b = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        bit          d1[BBA];
        bit          dr[BBA];
        logic [15:0] cap, cap2, cb;
        logic [15:0] capl[4];
        logic [15:0] g;
        logic [3:0]  o4, v;
        logic [3:0]  e_err;
        bit          dn, dany;
        int          done_cnt;
        string       s;
        byte         c;

        s = "123456789";
        for (int i = 0; i < 9; i++) begin
            c = s[i];
            for (int j = 0; j < 8; j++) d1[i*8+j] = c[7-j];
        end

        repeat (3) @(posedge clk);
        #1;
        rst_a = 1'b0;
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_reset_crc", crc_b, 64'h0);
        chk("b_reset_flags", {busy_b, done_b, ph_b, out_b, err_b}, 0);
        @(posedge clk); #1;

        // Unit A: known string, then START repulsed inside the CRC phase.
        a_block(1'b0, d1, 16'h0, 1'b1, 0, -1, cap, dn);
        chk("a_case1_crc_out", cap, 16'h31C3);
        chk("a_case1_done", dn, 1);
        a_block(1'b0, d1, 16'h0, 1'b1, 2, 5, cap, dn);
        chk("a_restart_crc_out", cap, 16'h31C3);
        chk("a_restart_done", dn, 1);
        a_block(1'b1, d1, 16'h31C3, 1'b1, 1, -1, cap, dn);
        chk("a_case1_check_err", err_a, 0);

        // Unit A: random loopback with ENA gaps.
        done_cnt = 0;
        for (int blk = 0; blk < 50; blk++) begin
            for (int i = 0; i < BBA; i++) dr[i] = 1'($urandom);
            a_block(1'b0, dr, 16'($urandom), 1'b1, 5, -1, cap, dn);
            a_block(1'b1, dr, cap, 1'b1, 5, -1, cap2, dn);
            chk("a_loop_err", err_a, 0);
            if (dn) done_cnt++;
            if (blk % 10 == 3) begin
                cb = cap ^ (16'h1 << $urandom_range(15, 0));
                a_block(1'b1, dr, cb, 1'b1, 3, -1, cap2, dn);
                chk("a_corrupt_err", err_a, 1);
            end
        end
        chk("a_done_count", done_cnt, 50);

        // Unit B: reset in the middle of the data phase.
        start_b = 1'b1;
        mode_b  = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < 300; i++) b_slot(4'hF, o4);
        rst_b = 1'b1;
        @(posedge clk); #1;
        rst_b = 1'b0;
        @(negedge clk);
        chk("b_rst_busy", busy_b, 0);
        chk("b_rst_crc", crc_b, 64'h0);
        dany = 1'b0;
        repeat (6) begin
            @(negedge clk);
            dany |= done_b;
        end
        chk("b_rst_no_done", dany, 0);
        @(posedge clk); #1;

        // Unit B: all-ones block, generate.
        start_b = 1'b1;
        mode_b  = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b0;
        for (int i = 0; i < BBB; i++) b_slot(4'hF, o4);
        chk("b_gen_phase", ph_b, 1);
        chk("b_gen_crc", crc_b, {4{16'h7FA1}});
        for (int k = 0; k < 16; k++) begin
            b_slot(4'($urandom), o4);
            for (int n = 0; n < 4; n++) capl[n][15-k] = o4[n];
        end
`ifdef SD_CRC_END_BIT_EN
        b_slot(4'($urandom), o4);
        chk("b_end_bit_out", o4, 4'hF);
`endif
        chk("b_gen_done", {done_b, busy_b}, 2'b10);
        chk("b_gen_serial", {capl[3], capl[2], capl[1], capl[0]},
            {4{16'h7FA1}});
        @(posedge clk); #1;

        // Unit B: check mode, lane 2 CRC bit 7 flipped.
        start_b = 1'b1;
        mode_b  = 1'b1;
        @(posedge clk); #1;
        start_b = 1'b0;
        g = 16'h7FA1;
        for (int i = 0; i < BBB; i++) b_slot(4'hF, o4);
        for (int k = 0; k < 16; k++) begin
            v = {4{g[15-k]}};
            if (15 - k == 7) v[2] = ~v[2];
            b_slot(v, o4);
            chk("b_chk_out_zero", o4, 4'h0);
        end
        e_err = 4'b0100;
`ifdef SD_CRC_END_BIT_EN
        b_slot(4'b1101, o4);
        e_err = 4'b0110;
`endif
        chk("b_chk_done", done_b, 1);
        chk("b_chk_err", err_b, e_err);
        @(posedge clk); #1;
        chk("b_chk_err_held", err_b, e_err);
        start_b = 1'b1;
        mode_b  = 1'b0;
        @(posedge clk); #1;
        start_b = 1'b0;
        chk("b_err_cleared", {err_b, busy_b}, 5'b00001);

        repeat (2) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
